// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    DRAIN,
    HALTED
  } hazard_state_t;

  localparam int MAX_WAIT_DEFAULT = 255;

  // Wait counter only has to reach MAX_WAIT-1, so it never needs to hold MAX_WAIT itself.
  function automatic int waitBits(input int maxWait);
    return (maxWait > 1) ? $clog2(maxWait) : 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int ADDR_LEFT = 4,
  parameter int CNT_BITS  = 16
);

  logic [ADDR_LEFT:0] rs_addr_s2, rt_addr_s2;
  logic               rs_used_s2, rt_used_s2;
  logic               rw_s3, rw_s4, rw_s5;
  logic [ADDR_LEFT:0] waddr_s3, waddr_s4, waddr_s5;
  logic               sel_mem_s3, branch_taken_s3;
  logic               mem_req_s4, mem_ack, halt_s4;

  logic               stall_s1, stall_s2, hold_s3, hold_s4;
  logic               flush_s2, bubble_s3, bubble_s5;
  logic               halted, mem_timeout;
  logic [CNT_BITS-1:0] stall_cnt;

  modport master (
    output rs_addr_s2, rt_addr_s2, rs_used_s2, rt_used_s2,
           rw_s3, rw_s4, rw_s5, waddr_s3, waddr_s4, waddr_s5,
           sel_mem_s3, branch_taken_s3, mem_req_s4, mem_ack, halt_s4,
    input  stall_s1, stall_s2, hold_s3, hold_s4,
           flush_s2, bubble_s3, bubble_s5, halted, mem_timeout, stall_cnt
  );

  modport slave (
    input  rs_addr_s2, rt_addr_s2, rs_used_s2, rt_used_s2,
           rw_s3, rw_s4, rw_s5, waddr_s3, waddr_s4, waddr_s5,
           sel_mem_s3, branch_taken_s3, mem_req_s4, mem_ack, halt_s4,
    output stall_s1, stall_s2, hold_s3, hold_s4,
           flush_s2, bubble_s3, bubble_s5, halted, mem_timeout, stall_cnt
  );

endinterface

// File: rtl/hazard_cmp.sv
// Matches one ID-stage source register against the EX/MEM/WB destinations.
// Build macro HAZARD_FORWARD_EN: only an EX-stage load conflicts; later stages are bypassed.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int ADDR_LEFT = 4
) (
  input  logic [ADDR_LEFT:0] i_srcAddr,
  input  logic               i_srcUsed,
  input  logic               i_rwS3,
  input  logic               i_rwS4,
  input  logic               i_rwS5,
  input  logic               i_selMemS3,
  input  logic [ADDR_LEFT:0] i_waddrS3,
  input  logic [ADDR_LEFT:0] i_waddrS4,
  input  logic [ADDR_LEFT:0] i_waddrS5,
  output logic               o_match
);

`ifdef HAZARD_FORWARD_EN
  localparam bit FORWARD = 1'b1;
`else
  localparam bit FORWARD = 1'b0;
`endif

  logic w_hitS3, w_hitS4, w_hitS5, w_needLoad;

  // r0 is hardwired to zero, so writes to it can never create a dependency.
  assign w_hitS3 = i_rwS3 && (i_waddrS3 == i_srcAddr) && (i_waddrS3 != '0);
  assign w_hitS4 = i_rwS4 && (i_waddrS4 == i_srcAddr) && (i_waddrS4 != '0);
  assign w_hitS5 = i_rwS5 && (i_waddrS5 == i_srcAddr) && (i_waddrS5 != '0);

  assign w_needLoad = FORWARD ? i_selMemS3 : 1'b1;
  assign o_match    = i_srcUsed &&
                      ((w_hitS3 && w_needLoad) || (!FORWARD && (w_hitS4 || w_hitS5)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use stall, halt drain.
// Build macro HAZARD_FORWARD_EN selects the forwarding-aware load-use check in hazard_cmp.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_WORDS = 32,
  parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
  parameter int MAX_WAIT  = MAX_WAIT_DEFAULT,
  parameter int CNT_BITS  = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int                   WAIT_BITS = waitBits(MAX_WAIT);
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(MAX_WAIT - 1);

  hazard_state_t        r_state, w_stateNext;
  logic [WAIT_BITS-1:0] r_waitCnt;
  logic                 r_timeout;
  logic [CNT_BITS-1:0]  r_stallCnt;

  logic w_rsHit, w_rtHit, w_hazard;
  logic w_freeze, w_freezeActive, w_timeoutNow;
  logic w_stallS1, w_stallS2, w_holdS3, w_holdS4;
  logic w_flushS2, w_bubbleS3, w_bubbleS5, w_halted;

  hazard_cmp #(.ADDR_LEFT(ADDR_LEFT)) u_cmpRs (
    .i_srcAddr (bus.rs_addr_s2),
    .i_srcUsed (bus.rs_used_s2),
    .i_rwS3    (bus.rw_s3),
    .i_rwS4    (bus.rw_s4),
    .i_rwS5    (bus.rw_s5),
    .i_selMemS3(bus.sel_mem_s3),
    .i_waddrS3 (bus.waddr_s3),
    .i_waddrS4 (bus.waddr_s4),
    .i_waddrS5 (bus.waddr_s5),
    .o_match   (w_rsHit)
  );

  hazard_cmp #(.ADDR_LEFT(ADDR_LEFT)) u_cmpRt (
    .i_srcAddr (bus.rt_addr_s2),
    .i_srcUsed (bus.rt_used_s2),
    .i_rwS3    (bus.rw_s3),
    .i_rwS4    (bus.rw_s4),
    .i_rwS5    (bus.rw_s5),
    .i_selMemS3(bus.sel_mem_s3),
    .i_waddrS3 (bus.waddr_s3),
    .i_waddrS4 (bus.waddr_s4),
    .i_waddrS5 (bus.waddr_s5),
    .o_match   (w_rtHit)
  );

  assign w_hazard       = w_rsHit || w_rtHit;
  assign w_freeze       = bus.mem_req_s4 && !bus.mem_ack;
  assign w_freezeActive = w_freeze && ((r_state == RUN) || (r_state == MEM_WAIT));
  // r_waitCnt holds the frozen cycles already elapsed, so this fires on the MAX_WAIT-th one.
  assign w_timeoutNow   = w_freezeActive && (r_waitCnt == WAIT_LAST);

  always_comb begin
    w_stateNext = r_state;
    w_stallS1   = 1'b0;
    w_stallS2   = 1'b0;
    w_holdS3    = 1'b0;
    w_holdS4    = 1'b0;
    w_flushS2   = 1'b0;
    w_bubbleS3  = 1'b0;
    w_bubbleS5  = 1'b0;
    w_halted    = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_freeze) begin
          {w_stallS1, w_stallS2, w_holdS3, w_holdS4, w_bubbleS5} = 5'b11111;
          w_stateNext = MEM_WAIT;
        end else begin
          if (bus.branch_taken_s3) begin
            w_flushS2  = 1'b1;
            w_bubbleS3 = 1'b1;
          end else if (w_hazard) begin
            w_stallS1  = 1'b1;
            w_stallS2  = 1'b1;
            w_bubbleS3 = 1'b1;
          end
          if (bus.halt_s4) w_stateNext = DRAIN;
        end
      end
      MEM_WAIT: begin
        if (w_freeze) begin
          {w_stallS1, w_stallS2, w_holdS3, w_holdS4, w_bubbleS5} = 5'b11111;
        end else begin
          w_stateNext = RUN;
        end
      end
      DRAIN: begin
        w_stallS1   = 1'b1;
        w_flushS2   = 1'b1;
        w_bubbleS3  = 1'b1;
        w_stateNext = HALTED;
      end
      HALTED: begin
        {w_stallS1, w_stallS2, w_holdS3, w_holdS4, w_bubbleS5} = 5'b11111;
        w_halted = 1'b1;
      end
      default: w_stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_waitCnt  <= '0;
      r_timeout  <= 1'b0;
      r_stallCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_freezeActive) begin
        if (r_waitCnt != WAIT_LAST) r_waitCnt <= r_waitCnt + 1'b1;
      end else begin
        r_waitCnt <= '0;
      end
      if (w_timeoutNow) r_timeout <= 1'b1;
      if ((w_stallS1 || w_holdS4) && (r_state != HALTED) && (r_stallCnt != '1))
        r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  // Reset masks every flag combinationally, even mid-wait or mid-drain.
  assign bus.stall_s1    = w_stallS1  && !rst;
  assign bus.stall_s2    = w_stallS2  && !rst;
  assign bus.hold_s3     = w_holdS3   && !rst;
  assign bus.hold_s4     = w_holdS4   && !rst;
  assign bus.flush_s2    = w_flushS2  && !rst;
  assign bus.bubble_s3   = w_bubbleS3 && !rst;
  assign bus.bubble_s5   = w_bubbleS5 && !rst;
  assign bus.halted      = w_halted   && !rst;
  assign bus.mem_timeout = (r_timeout || w_timeoutNow) && !rst;
  assign bus.stall_cnt   = r_stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic vs a reference model.
module tb_hazard_ctrl;

  localparam int AL      = 4;
  localparam int MW      = 4;
  localparam int CB      = 6;
  localparam int CNT_MAX = (1 << CB) - 1;

  typedef logic [AL:0] addr_t;

  typedef struct packed {
    addr_t      rs, rt;
    logic       rsUsed, rtUsed;
    logic [2:0] rw;
    addr_t      wa3, wa4, wa5;
    logic       selMem, branch, memReq, memAck, halt;
  } stim_t;

  typedef struct packed {
    logic s1, s2, h3, h4, f2, b3, b5, hl, tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model: reset state is all zeros, which matches the first reset edge.
  bit mHalted  = 1'b0;
  bit mDrain   = 1'b0;
  bit mWait    = 1'b0;
  bit mTimeout = 1'b0;
  int mFrozen  = 0;
  int mCount   = 0;

  hazard_ctrl_if #(.ADDR_LEFT(AL), .CNT_BITS(CB)) bus ();

  hazard_ctrl #(
    .REG_WORDS(32),
    .ADDR_LEFT(AL),
    .MAX_WAIT (MW),
    .CNT_BITS (CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit srcBlocked(input addr_t src, input bit used, input stim_t s);
    addr_t dst[3];
    dst[0] = s.wa3;
    dst[1] = s.wa4;
    dst[2] = s.wa5;
    if (!used || src == 0) return 1'b0;
    for (int k = 0; k < 3; k++) begin
`ifdef HAZARD_FORWARD_EN
      if (k == 0 && s.rw[0] && s.selMem && dst[0] == src) return 1'b1;
`else
      if (s.rw[k] && dst[k] == src) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  task automatic applyStimulus(input stim_t s, input bit r);
    rst                 = r;
    bus.rs_addr_s2      = s.rs;
    bus.rt_addr_s2      = s.rt;
    bus.rs_used_s2      = s.rsUsed;
    bus.rt_used_s2      = s.rtUsed;
    bus.rw_s3           = s.rw[0];
    bus.rw_s4           = s.rw[1];
    bus.rw_s5           = s.rw[2];
    bus.waddr_s3        = s.wa3;
    bus.waddr_s4        = s.wa4;
    bus.waddr_s5        = s.wa5;
    bus.sel_mem_s3      = s.selMem;
    bus.branch_taken_s3 = s.branch;
    bus.mem_req_s4      = s.memReq;
    bus.mem_ack         = s.memAck;
    bus.halt_s4         = s.halt;
  endtask

  // Compares every output with the model's prediction, then advances the model across the edge.
  task automatic checkOutput(input stim_t s, input bit r, input string tag);
    exp_t e;
    bit   freeze, tmoNow, hazard;
    e      = '0;
    freeze = s.memReq && !s.memAck;
    tmoNow = 1'b0;
    hazard = srcBlocked(s.rs, s.rsUsed, s) || srcBlocked(s.rt, s.rtUsed, s);
    if (!r) begin
      if (mHalted) begin
        {e.s1, e.s2, e.h3, e.h4, e.b5, e.hl} = 6'b111111;
      end else if (mDrain) begin
        {e.s1, e.f2, e.b3} = 3'b111;
      end else if (freeze) begin
        {e.s1, e.s2, e.h3, e.h4, e.b5} = 5'b11111;
        tmoNow = (mFrozen + 1 >= MW);
      end else if (!mWait) begin
        if (s.branch) {e.f2, e.b3} = 2'b11;
        else if (hazard) {e.s1, e.s2, e.b3} = 3'b111;
      end
      e.tmo = mTimeout || tmoNow;
    end

    checkBit({tag, ".stall_s1"},    bus.stall_s1,    e.s1);
    checkBit({tag, ".stall_s2"},    bus.stall_s2,    e.s2);
    checkBit({tag, ".hold_s3"},     bus.hold_s3,     e.h3);
    checkBit({tag, ".hold_s4"},     bus.hold_s4,     e.h4);
    checkBit({tag, ".flush_s2"},    bus.flush_s2,    e.f2);
    checkBit({tag, ".bubble_s3"},   bus.bubble_s3,   e.b3);
    checkBit({tag, ".bubble_s5"},   bus.bubble_s5,   e.b5);
    checkBit({tag, ".halted"},      bus.halted,      e.hl);
    checkBit({tag, ".mem_timeout"}, bus.mem_timeout, e.tmo);
    checkValue({tag, ".stall_cnt"}, 32'(bus.stall_cnt), mCount);

    if (r) begin
      {mHalted, mDrain, mWait, mTimeout} = 4'b0000;
      mFrozen = 0;
      mCount  = 0;
    end else begin
      if (!mHalted && (e.s1 || e.h4)) mCount = (mCount >= CNT_MAX) ? CNT_MAX : mCount + 1;
      if (!mHalted) begin
        if (mDrain) begin
          mDrain  = 1'b0;
          mHalted = 1'b1;
        end else if (freeze) begin
          mWait = 1'b1;
          mFrozen++;
          if (tmoNow) mTimeout = 1'b1;
        end else begin
          if (!mWait && s.halt) mDrain = 1'b1;
          mWait   = 1'b0;
          mFrozen = 0;
        end
      end
    end
  endtask

  task automatic runCycle(input stim_t s, input bit r, input string tag);
    applyStimulus(s, r);
    @(negedge clk);
    checkOutput(s, r, tag);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t randomStim();
    stim_t s;
    s.rs     = addr_t'($urandom_range(0, 7));
    s.rt     = addr_t'($urandom_range(0, 7));
    s.rsUsed = ($urandom_range(0, 3) != 0);
    s.rtUsed = ($urandom_range(0, 3) != 0);
    s.rw     = 3'($urandom_range(0, 7));
    s.wa3    = addr_t'($urandom_range(0, 7));
    s.wa4    = addr_t'($urandom_range(0, 7));
    s.wa5    = addr_t'($urandom_range(0, 7));
    s.selMem = 1'($urandom_range(0, 1));
    s.branch = ($urandom_range(0, 9) == 0);
    s.memReq = ($urandom_range(0, 3) == 0);
    s.memAck = 1'($urandom_range(0, 1));
    s.halt   = ($urandom_range(0, 39) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    stim_t idle;
    stim_t frz;
    stim_t ack;
    int    expCnt;
    bit    r;

    idle = '0;
    frz  = '0;
    frz.memReq = 1'b1;
    ack  = frz;
    ack.memAck = 1'b1;

    $display("[TB] start");
    applyStimulus(idle, 1'b1);
    @(posedge clk);
    #1;
    runCycle(idle, 1'b1, "reset");
    runCycle(idle, 1'b0, "idle");
    checkValue("cntAfterReset", 32'(bus.stall_cnt), 0);

    // Load in EX feeding rs, then the same load one stage further on.
    s = '0;
    s.rs = 5; s.rsUsed = 1'b1; s.rw = 3'b001; s.wa3 = 5; s.selMem = 1'b1;
    runCycle(s, 1'b0, "loadUse");
    s = '0;
    s.rs = 5; s.rsUsed = 1'b1; s.rw = 3'b010; s.wa4 = 5;
    runCycle(s, 1'b0, "loadUseNext");
`ifdef HAZARD_FORWARD_EN
    expCnt = 1;
`else
    expCnt = 2;
`endif
    checkValue("loadUseCnt", 32'(bus.stall_cnt), expCnt);

    // Branch wins over a simultaneous load-use.
    s = '0;
    s.rs = 5; s.rsUsed = 1'b1; s.rw = 3'b001; s.wa3 = 5; s.selMem = 1'b1; s.branch = 1'b1;
    runCycle(s, 1'b0, "branchOverStall");
    runCycle(idle, 1'b0, "idle");

    s = '0;
    s.rs = 0; s.rsUsed = 1'b1; s.rw = 3'b001; s.wa3 = 0; s.selMem = 1'b1;
    runCycle(s, 1'b0, "reg0");
    s = '0;
    s.rt = 7; s.rtUsed = 1'b1; s.rw = 3'b100; s.wa5 = 7;
    runCycle(s, 1'b0, "wbMatch");

    // Three frozen cycles, released in the ack cycle.
    runCycle(idle, 1'b1, "reset");
    for (int i = 0; i < 3; i++) runCycle(frz, 1'b0, "memWait");
    runCycle(ack, 1'b0, "memAck");
    checkValue("memWaitCnt", 32'(bus.stall_cnt), 3);
    runCycle(idle, 1'b0, "idle");

    runCycle(idle, 1'b1, "reset");
    for (int i = 0; i < 6; i++) runCycle(frz, 1'b0, "timeout");
    runCycle(ack, 1'b0, "timeoutAck");
    checkBit("timeoutSticky", bus.mem_timeout, 1'b1);
    runCycle(idle, 1'b0, "idle");

    runCycle(idle, 1'b1, "reset");
    s = '0;
    s.halt = 1'b1;
    runCycle(s, 1'b0, "halt");
    runCycle(idle, 1'b0, "drain");
    for (int i = 0; i < 4; i++) runCycle(randomStim(), 1'b0, "halted");
    checkBit("haltedHeld", bus.halted, 1'b1);
    runCycle(idle, 1'b1, "haltReset");
    runCycle(idle, 1'b0, "afterHalt");

    runCycle(idle, 1'b1, "reset");
    for (int i = 0; i < 70; i++) runCycle(frz, 1'b0, "saturate");
    runCycle(ack, 1'b0, "saturateAck");
    checkValue("cntSaturated", 32'(bus.stall_cnt), CNT_MAX);

    runCycle(idle, 1'b1, "reset");
    for (int i = 0; i < 400; i++) begin
      r = mHalted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0);
      runCycle(randomStim(), r, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_WORDS, default 32, register-file depth.
REQ-002 SHALL have parameter ADDR_LEFT, default $clog2(REG_WORDS)-1, register-address MSB.
REQ-003 SHALL have parameter MAX_WAIT, default 255, memory-wait timeout in cycles.
REQ-004 SHALL have parameter CNT_BITS, default 16, stall-counter width.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, one clock, reset synchronous and active-high.
REQ-006 SHALL have ports: rs_addr_s2, rt_addr_s2 in ADDR_LEFT+1, ID-stage sources; rs_used_s2, rt_used_s2 in 1, source valid.
REQ-007 SHALL have ports: rw_s3/rw_s4/rw_s5 in 1, write-enable per stage; waddr_s3/waddr_s4/waddr_s5 in ADDR_LEFT+1, destinations; sel_mem_s3 in 1, EX instruction is a load.
REQ-008 SHALL have ports: branch_taken_s3 in 1, redirect; mem_req_s4 in 1, MEM access active; mem_ack in 1, data memory done; halt_s4 in 1, halt reached MEM.
REQ-009 SHALL have outputs: stall_s1, stall_s2, hold_s3, hold_s4 out 1, register holds; flush_s2, bubble_s3, bubble_s5 out 1, insert NOP; halted out 1; mem_timeout out 1; stall_cnt out CNT_BITS.

Function
REQ-010 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, HALTED.
REQ-011 SHALL define freeze = mem_req_s4 & ~mem_ack, evaluated combinationally in RUN and MEM_WAIT.
REQ-012 SHALL, on freeze, assert stall_s1, stall_s2, hold_s3, hold_s4, bubble_s5 in the same cycle; RUN->MEM_WAIT next edge.
REQ-013 SHALL, in MEM_WAIT, return to RUN on the edge after mem_ack=1; the ack cycle deasserts all holds (zero added latency).
REQ-014 SHALL count MEM_WAIT cycles; on reaching MAX_WAIT set sticky mem_timeout, remain in MEM_WAIT until ack.
REQ-015 SHALL, in RUN with no freeze, on branch_taken_s3 assert flush_s2 and bubble_s3 for exactly one cycle.
REQ-016 SHALL, in RUN with no freeze and no branch, on load-use hazard assert stall_s1, stall_s2, bubble_s3.
REQ-017 SHALL never flag a hazard for destination address 0 or an unused source.
REQ-018 SHALL apply priority freeze > branch flush > hazard stall; lower-priority actions in the same cycle are suppressed and re-evaluated next cycle.
REQ-019 SHALL, in RUN with halt_s4 and no freeze, go to DRAIN; DRAIN asserts stall_s1, flush_s2, bubble_s3 for one cycle, then HALTED.
REQ-020 SHALL, in HALTED, assert halted, stall_s1, stall_s2, hold_s3, hold_s4, bubble_s5 until reset.
REQ-021 SHALL increment stall_cnt each cycle any of stall_s1/hold_s4 is asserted outside HALTED, saturating at all-ones.

Reset
REQ-022 SHALL, when rst=1 at a clk edge, set state RUN, wait counter 0, mem_timeout 0, stall_cnt 0.
REQ-023 SHALL force all 1-bit outputs to 0 while rst=1, including mid-MEM_WAIT or DRAIN.

Configuration
REQ-024 SHALL use macro HAZARD_FORWARD_EN.
REQ-025 SHALL, with HAZARD_FORWARD_EN defined, flag hazard only when rw_s3 & sel_mem_s3 and waddr_s3 matches a used source (one-cycle load-use stall).
REQ-026 SHALL, without it, flag hazard when any of stages s3, s4, s5 has rw set and waddr matching a used source (stall until retirement).

Structure
REQ-027 SHALL place FSM state enum and MAX_WAIT default in shared package hazard_pkg.
REQ-028 SHALL implement source-match logic as sub-module hazard_cmp (one source vs three stages).

Verification
REQ-029 SHALL cover: lw r5 in s3 (sel_mem_s3=1, waddr_s3=5), rs_addr_s2=5 used -> stall_s1/stall_s2/bubble_s3=1 for 1 cycle (FORWARD_EN).
REQ-030 SHALL cover: mem_req_s4=1, mem_ack low 3 cycles -> holds asserted 3 cycles, released in ack cycle, stall_cnt=3.
REQ-031 SHALL cover: branch_taken_s3=1 with simultaneous load-use -> flush_s2=bubble_s3=1, stall_s1=0.
REQ-032 SHALL cover: MAX_WAIT=4, no ack 6 cycles -> mem_timeout=1 from cycle 4, sticky after ack.
REQ-033 SHALL cover: halt_s4=1 -> DRAIN 1 cycle, then halted=1 held; rst=1 -> halted=0 same cycle, RUN next.
REQ-034 SHALL cover: waddr_s3=0 with rs_addr_s2=0 -> no stall; without FORWARD_EN, rw_s5 waddr_s5=7, rt_addr_s2=7 -> stall.
